// File: rtl/tlb_pkg.sv
// Shared constants and the key type for the TLB key memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tlb_pkg;

    localparam int TLB_ENTRIES     = 32;
    localparam int TLB_INDEX_WIDTH = 5;
    localparam int TLB_KEY_WIDTH   = 20;

    // Virtual page number held in one TLB key entry.
    typedef logic [TLB_KEY_WIDTH-1:0] key_t;

endpackage

// File: rtl/tlb_key_match_encoder.sv
// Reduces a per-entry match vector to found / lowest matching index (and multiHit when
// TLB_KEY_MULTIHIT_EN is defined). Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
// Ports: match_vec (in, ENTRIES), found (out), foundIndex (out, INDEX_WIDTH), multiHit (out, optional).
module tlb_key_match_encoder
    import tlb_pkg::*;
#(
    parameter int ENTRIES     = TLB_ENTRIES,
    parameter int INDEX_WIDTH = TLB_INDEX_WIDTH
) (
    input  logic [ENTRIES-1:0]     match_vec,
    output logic                   found,
    output logic [INDEX_WIDTH-1:0] foundIndex
`ifdef TLB_KEY_MULTIHIT_EN
    ,
    output logic                   multiHit
`endif
);

    assign found = |match_vec;

    // Scan from the top down so the last assignment is the lowest set bit.
    // With no match nothing is assigned and the index stays 0.
    always_comb begin
        foundIndex = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                foundIndex = INDEX_WIDTH'(i);
            end
        end
    end

`ifdef TLB_KEY_MULTIHIT_EN
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multiHit = |(match_vec & (match_vec - ENTRIES'(1)));
`endif

endmodule

// File: rtl/tlb_key_memory.sv
// TLB key store: ENTRIES keys with combinational read and parallel associative search.
// Latency: read and search zero cycles; write lands at the next rising clock edge.
// Backpressure: none, writes are always accepted. Optional multiHit via TLB_KEY_MULTIHIT_EN.
// Ports: clock, reset (async active-high, clears all keys), accessIndex/readValue (read),
// writeValue/writeEnable (write), searchKey/found/foundIndex[/multiHit] (search).
module tlb_key_memory
    import tlb_pkg::*;
#(
    parameter int ENTRIES     = TLB_ENTRIES,
    parameter int INDEX_WIDTH = TLB_INDEX_WIDTH,
    parameter int KEY_WIDTH   = TLB_KEY_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] accessIndex,
    output logic [KEY_WIDTH-1:0]   readValue,
    input  logic [KEY_WIDTH-1:0]   writeValue,
    input  logic                   writeEnable,
    input  logic [KEY_WIDTH-1:0]   searchKey,
    output logic                   found,
    output logic [INDEX_WIDTH-1:0] foundIndex
`ifdef TLB_KEY_MULTIHIT_EN
    ,
    output logic                   multiHit
`endif
);

    // Kept under this name so benches can reach entries hierarchically.
    logic [KEY_WIDTH-1:0] keyArray   [ENTRIES];
    logic [KEY_WIDTH-1:0] key_array_d[ENTRIES];
    logic [ENTRIES-1:0]   match_vec;

    always_comb begin
        key_array_d = keyArray;
        if (writeEnable) begin
            key_array_d[accessIndex] = writeValue;
        end
    end

    // Reset wins over writeEnable; every entry clears immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                keyArray[i] <= '0;
            end
        end else begin
            keyArray <= key_array_d;
        end
    end

    assign readValue = keyArray[accessIndex];

    // Zero is an ordinary key: there is no valid bit gating the compare.
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match_vec[i] = (keyArray[i] == searchKey);
        end
    end

    tlb_key_match_encoder #(
        .ENTRIES     (ENTRIES),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_encoder (
        .match_vec  (match_vec),
        .found      (found),
        .foundIndex (foundIndex)
`ifdef TLB_KEY_MULTIHIT_EN
        ,
        .multiHit   (multiHit)
`endif
    );

endmodule

// File: tb/tb_tlb_key_memory.sv
module tb_tlb_key_memory;
    import tlb_pkg::*;

    localparam int N = TLB_ENTRIES;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  accessIndex;
    key_t        readValue;
    key_t        writeValue;
    logic        writeEnable;
    key_t        searchKey;
    logic        found;
    logic [4:0]  foundIndex;
`ifdef TLB_KEY_MULTIHIT_EN
    logic        multiHit;
`endif

    tlb_key_memory dut (
        .clock       (clock),
        .reset       (reset),
        .accessIndex (accessIndex),
        .readValue   (readValue),
        .writeValue  (writeValue),
        .writeEnable (writeEnable),
        .searchKey   (searchKey),
        .found       (found),
        .foundIndex  (foundIndex)
`ifdef TLB_KEY_MULTIHIT_EN
        ,
        .multiHit    (multiHit)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int mdl [N];

    typedef struct {
        int idx;
        int skey;
        int exp_read;
        int exp_found;
        int exp_fidx;
        int exp_mh;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a write on the falling edge; it lands at the following rising edge.
    task automatic do_write(input int idx, input int val);
        @(negedge clock);
        accessIndex = idx[4:0];
        writeValue  = val[19:0];
        writeEnable = 1'b1;
        @(posedge clock);
        #1 writeEnable = 1'b0;
        mdl[idx] = val;
    endtask

    // Reference search: count all hits, remember the first.
    task automatic model_search(input int key, output int f, output int fi, output int mh);
        int cnt;
        cnt = 0;
        fi  = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mdl[i] == key) begin
                cnt++;
                fi = i;
            end
        end
        f  = (cnt > 0) ? 1 : 0;
        mh = (cnt > 1) ? 1 : 0;
    endtask

    task automatic check_against_model(input string tag, input int idx, input int key);
        int f, fi, mh;
        accessIndex = idx[4:0];
        searchKey   = key[19:0];
        #1;
        model_search(key, f, fi, mh);
        chk({tag, "_read"},  32'(readValue),  32'(mdl[idx]));
        chk({tag, "_found"}, 32'(found),      32'(f));
        chk({tag, "_fidx"},  32'(foundIndex), 32'(fi));
`ifdef TLB_KEY_MULTIHIT_EN
        chk({tag, "_mhit"},  32'(multiHit),   32'(mh));
`else
        mh = mh;
`endif
    endtask

    initial begin
        int key_pool [8];
        reset       = 1'b1;
        accessIndex = '0;
        writeValue  = '0;
        writeEnable = 1'b0;
        searchKey   = '0;
        for (int i = 0; i < N; i++) mdl[i] = 0;

        // Reset state.
        #1;
        chk("rst_read",  32'(readValue),  32'h0);
        chk("rst_found", 32'(found),      32'h1);
        chk("rst_fidx",  32'(foundIndex), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Preload through the write port.
        do_write(5, 'h12345);
        do_write(3, 'h44444);
        do_write(7, 'h44444);

        vecs[0] = '{idx: 2, skey: 'h12121, exp_read: 'h00000, exp_found: 0, exp_fidx: 0, exp_mh: 0};
        vecs[1] = '{idx: 3, skey: 'h12345, exp_read: 'h44444, exp_found: 1, exp_fidx: 5, exp_mh: 0};
        vecs[2] = '{idx: 4, skey: 'h44444, exp_read: 'h00000, exp_found: 1, exp_fidx: 3, exp_mh: 1};
        vecs[3] = '{idx: 5, skey: 'h00000, exp_read: 'h12345, exp_found: 1, exp_fidx: 0, exp_mh: 1};
        vecs[4] = '{idx: 7, skey: 'h12345, exp_read: 'h44444, exp_found: 1, exp_fidx: 5, exp_mh: 0};
        vecs[5] = '{idx: 0, skey: 'h44445, exp_read: 'h00000, exp_found: 0, exp_fidx: 0, exp_mh: 0};
        vecs[6] = '{idx: 31, skey: 'h44444, exp_read: 'h00000, exp_found: 1, exp_fidx: 3, exp_mh: 1};
        vecs[7] = '{idx: 6, skey: 'h12344, exp_read: 'h00000, exp_found: 0, exp_fidx: 0, exp_mh: 0};

        for (int v = 0; v < 8; v++) begin
            accessIndex = vecs[v].idx[4:0];
            searchKey   = vecs[v].skey[19:0];
            #1;
            chk($sformatf("vec%0d_read", v),  32'(readValue),  32'(vecs[v].exp_read));
            chk($sformatf("vec%0d_found", v), 32'(found),      32'(vecs[v].exp_found));
            chk($sformatf("vec%0d_fidx", v),  32'(foundIndex), 32'(vecs[v].exp_fidx));
`ifdef TLB_KEY_MULTIHIT_EN
            chk($sformatf("vec%0d_mhit", v), 32'(multiHit), 32'(vecs[v].exp_mh));
`endif
        end

        // Write to entry 6: old value visible until the edge.
        @(negedge clock);
        accessIndex = 5'd6;
        writeValue  = 20'h91919;
        writeEnable = 1'b1;
        searchKey   = 20'h91919;
        #1;
        chk("wr6_pre_read",  32'(readValue), 32'h0);
        chk("wr6_pre_found", 32'(found),     32'h0);
        @(posedge clock);
        #1 writeEnable = 1'b0;
        mdl[6] = 'h91919;
        chk("wr6_post_read", 32'(readValue),  32'h91919);
        chk("wr6_post_fidx", 32'(foundIndex), 32'h6);
        chk("wr6_post_fnd",  32'(found),      32'h1);

        // Boundary indices.
        do_write(31, 'hFFFFF);
        do_write(0, 'h00001);
        accessIndex = 5'd31;
        searchKey   = 20'hFFFFF;
        #1;
        chk("bnd_read31", 32'(readValue),  32'hFFFFF);
        chk("bnd_fidx31", 32'(foundIndex), 32'd31);
        chk("bnd_found",  32'(found),      32'h1);
        accessIndex = 5'd0;
        searchKey   = 20'h00000;
        #1;
        chk("bnd_read0",  32'(readValue),  32'h00001);
        chk("bnd_zero_fidx", 32'(foundIndex), 32'd1);

        // Randomized writes and lookups against the reference array.
        key_pool = '{'h00000, 'h44444, 'h12345, 'hFFFFF, 'h00001, 'hABCDE, 'h91919, 'h55555};
        for (int r = 0; r < 300; r++) begin
            int idx, key;
            idx = int'($urandom_range(0, N - 1));
            key = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20'hFFFFF))
                                              : key_pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 2) == 0) begin
                do_write(idx, key);
            end
            check_against_model("rnd", int'($urandom_range(0, N - 1)),
                                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20'hFFFFF))
                                                            : key_pool[$urandom_range(0, 7)]);
        end

        // Reset asserted mid-cycle after writes clears everything at once.
        do_write(9, 'h77777);
        @(posedge clock);
        #2;
        accessIndex = 5'd9;
        searchKey   = 20'h77777;
        #1;
        chk("prerst_read", 32'(readValue), 32'h77777);
        reset = 1'b1;
        #1;
        for (int i = 0; i < N; i++) mdl[i] = 0;
        chk("rst_mid_read",  32'(readValue), 32'h0);
        chk("rst_mid_found", 32'(found),     32'h0);
        // A write while reset is held must be dropped.
        writeValue  = 20'h33333;
        writeEnable = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_wr_ignored", 32'(readValue), 32'h0);
        searchKey = 20'h0;
        #1;
        chk("rst_zero_found", 32'(found),      32'h1);
        chk("rst_zero_fidx",  32'(foundIndex), 32'h0);
        @(negedge clock);
        writeEnable = 1'b0;
        reset       = 1'b0;

        // Normal operation resumes after reset.
        do_write(12, 'h2468A);
        check_against_model("post_rst", 12, 'h2468A);
        check_against_model("post_rst0", 3, 'h44444);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

endmodule
